// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: branch resolve, two-entry skid buffer toward MEM,
// and a forwarding tap from the youngest buffered result.
module ex_mem_stage #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [DATA_W-1:0] aluResult,
  input  logic              zeroFlag,
  input  logic [DATA_W-1:0] storeData,
  input  logic [REG_W-1:0]  rdAddr,
  input  logic              regWrite,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              branch,
  input  logic              branchNe,
  input  logic [DATA_W-1:0] branchTarget,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_aluResult,
  output logic [DATA_W-1:0] out_storeData,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_regWrite,
  output logic              out_memRead,
  output logic              out_memWrite,
  output logic              redirect,
  output logic [DATA_W-1:0] redirectPc,
  output logic              fwdValid,
  output logic [REG_W-1:0]  fwdRd,
  output logic [DATA_W-1:0] fwdData
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sd;
    logic [REG_W-1:0]  rd;
    logic              rw;
    logic              mr;
    logic              mw;
  } ent_t;

  ent_t        h_q, s_q, h_d, s_d, in_e;
  logic [1:0]  cnt_q, cnt_d;
  logic        rdy_q;
  logic        acc, enq, deq, taken;
  logic        redir_q;
  logic [DATA_W-1:0] pc_q;
  logic        y_rw, y_mr;
  logic [REG_W-1:0]  y_rd;
  logic [DATA_W-1:0] y_alu;

  assign acc   = in_valid & rdy_q & ~flush;
  assign enq   = acc & ~branch;
  assign deq   = (cnt_q != 2'd0) & out_ready;
  assign taken = zeroFlag ^ branchNe;

  // x0 is never a real writeback target
  assign in_e = '{
    alu: aluResult,
    sd:  storeData,
    rd:  rdAddr,
    rw:  regWrite & (rdAddr != '0),
    mr:  memRead,
    mw:  memWrite
  };

  always_comb begin
    h_d   = h_q;
    s_d   = s_q;
    cnt_d = cnt_q;
    case ({enq, deq})
      2'b11: begin
        if (cnt_q == 2'd2) begin
          h_d = s_q;
          s_d = in_e;
        end else begin
          h_d = in_e;
        end
      end
      2'b10: begin
        if (cnt_q == 2'd0) begin
          h_d   = in_e;
          cnt_d = 2'd1;
        end else if (cnt_q == 2'd1) begin
          s_d   = in_e;
          cnt_d = 2'd2;
        end
      end
      2'b01: begin
        if (cnt_q == 2'd2) h_d = s_q;
        cnt_d = cnt_q - 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q     <= '0;
      s_q     <= '0;
      cnt_q   <= 2'd0;
      rdy_q   <= 1'b1;
      redir_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      h_q     <= h_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (cnt_d != 2'd2);
      redir_q <= acc & branch & taken;
      if (acc & branch & taken) pc_q <= branchTarget;
    end
  end

  assign in_ready      = rdy_q;
  assign out_valid     = (cnt_q != 2'd0);
  assign out_aluResult = h_q.alu;
  assign out_storeData = h_q.sd;
  assign out_rd        = h_q.rd;
  assign out_regWrite  = h_q.rw;
  assign out_memRead   = h_q.mr;
  assign out_memWrite  = h_q.mw;
  assign redirect      = redir_q;
  assign redirectPc    = pc_q;

  // youngest entry: skid when full, else head
  assign y_rw  = (cnt_q == 2'd2) ? s_q.rw  : h_q.rw;
  assign y_mr  = (cnt_q == 2'd2) ? s_q.mr  : h_q.mr;
  assign y_rd  = (cnt_q == 2'd2) ? s_q.rd  : h_q.rd;
  assign y_alu = (cnt_q == 2'd2) ? s_q.alu : h_q.alu;

  assign fwdValid = (cnt_q != 2'd0) & y_rw & ~y_mr;
  assign fwdRd    = fwdValid ? y_rd  : '0;
  assign fwdData  = fwdValid ? y_alu : '0;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: random and directed traffic
// checked against a queue model of the buffered instructions.
module tb_ex_mem_stage;
  localparam int DW = 64;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, flush;
  logic [DW-1:0] aluResult, storeData, branchTarget;
  logic          zeroFlag;
  logic [RW-1:0] rdAddr;
  logic          regWrite, memRead, memWrite, branch, branchNe;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_aluResult, out_storeData;
  logic [RW-1:0] out_rd;
  logic          out_regWrite, out_memRead, out_memWrite;
  logic          redirect;
  logic [DW-1:0] redirectPc;
  logic          fwdValid;
  logic [RW-1:0] fwdRd;
  logic [DW-1:0] fwdData;

  ex_mem_stage #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .aluResult(aluResult), .zeroFlag(zeroFlag),
    .storeData(storeData), .rdAddr(rdAddr),
    .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .branch(branch), .branchNe(branchNe),
    .branchTarget(branchTarget),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_aluResult(out_aluResult), .out_storeData(out_storeData),
    .out_rd(out_rd), .out_regWrite(out_regWrite),
    .out_memRead(out_memRead), .out_memWrite(out_memWrite),
    .redirect(redirect), .redirectPc(redirectPc),
    .fwdValid(fwdValid), .fwdRd(fwdRd), .fwdData(fwdData)
  );

  typedef struct {
    logic [DW-1:0] alu;
    logic [DW-1:0] sd;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          mw;
  } exp_t;

  exp_t exp_q[$];
  int   held = 0;
  bit   enq_now = 0, br_now = 0, br_tk = 0;
  logic [DW-1:0] br_pc = '0;
  bit   exp_redir = 0;
  logic [DW-1:0] exp_pc = '0;
  bit   mon_en = 0;
  int   errors = 0, checks = 0;
  exp_t y, f;
  bit   fwd_ok;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: compare visible state, then advance the model one edge
  always @(negedge clk) if (mon_en) begin
    chk("out_valid", out_valid, held != 0);
    chk("in_ready", in_ready, held != 2);
    chk("redirect", redirect, exp_redir);
    if (exp_redir) chk("redirectPc", redirectPc, exp_pc);
    fwd_ok = 0;
    if (held > 0) begin
      y = exp_q[held-1];
      fwd_ok = y.rw && !y.mr;
    end
    chk("fwdValid", fwdValid, fwd_ok);
    if (fwd_ok) begin
      chk("fwdRd", fwdRd, y.rd);
      chk("fwdData", fwdData, y.alu);
    end
    if (held > 0 && out_ready) begin
      f = exp_q.pop_front();
      held--;
      chk("out_aluResult", out_aluResult, f.alu);
      chk("out_storeData", out_storeData, f.sd);
      chk("out_rd", out_rd, f.rd);
      chk("out_regWrite", out_regWrite, f.rw);
      chk("out_memRead", out_memRead, f.mr);
      chk("out_memWrite", out_memWrite, f.mw);
    end
    if (enq_now) held++;
    exp_redir = br_now && br_tk;
    exp_pc = br_pc;
  end

  task automatic issue(input logic v, input logic fl, input logic br,
                       input logic bne, input logic zf, input logic ordy,
                       input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                       input logic [DW-1:0] tgt, input logic [RW-1:0] rd,
                       input logic rw, input logic mr, input logic mw);
    bit acc;
    @(posedge clk);
    #1;
    in_valid = v; flush = fl; branch = br; branchNe = bne;
    zeroFlag = zf; out_ready = ordy; aluResult = alu;
    storeData = sd; branchTarget = tgt; rdAddr = rd;
    regWrite = rw; memRead = mr; memWrite = mw;
    acc = v && !fl && (held != 2);
    enq_now = acc && !br;
    br_now = acc && br;
    br_tk = bne ? !zf : zf;
    br_pc = tgt;
    if (enq_now)
      exp_q.push_back('{alu, sd, rd, rw && (rd != 0), mr, mw});
  endtask

  task automatic idle(input logic ordy);
    issue(0, 0, 0, 0, 0, ordy, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alu_op(input logic [DW-1:0] a, input logic [RW-1:0] rd,
                        input logic ordy);
    issue(1, 0, 0, 0, a == 0, ordy, a, ~a, 0, rd, 1, 0, 0);
  endtask

  task automatic rand_cycle();
    logic [DW-1:0] a;
    logic [RW-1:0] r;
    logic br, mr;
    a = ($urandom_range(0, 9) == 0) ? '0 : {$urandom, $urandom};
    r = ($urandom_range(0, 5) == 0) ? '0 : RW'($urandom);
    br = ($urandom_range(0, 5) == 0);
    mr = ($urandom_range(0, 3) == 0);
    issue($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, br,
          1'($urandom), br ? 1'($urandom) : (a == 0),
          $urandom_range(0, 9) < 7, a, {$urandom, $urandom},
          {$urandom, $urandom}, r, 1'($urandom), mr,
          !mr && ($urandom_range(0, 3) == 0));
  endtask

  task automatic model_clear();
    exp_q.delete();
    held = 0;
    enq_now = 0;
    br_now = 0;
    exp_redir = 0;
  endtask

  initial begin
    in_valid = 0; flush = 0; aluResult = 0; zeroFlag = 0;
    storeData = 0; rdAddr = 0; regWrite = 0; memRead = 0;
    memWrite = 0; branch = 0; branchNe = 0; branchTarget = 0;
    out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst redirect", redirect, 0);
    chk("rst redirectPc", redirectPc, 0);
    chk("rst fwdValid", fwdValid, 0);
    chk("rst fwdRd", fwdRd, 0);
    chk("rst fwdData", fwdData, 0);
    chk("rst out_aluResult", out_aluResult, 0);
    chk("rst out_rd", out_rd, 0);
    chk("rst out_regWrite", out_regWrite, 0);
    @(posedge clk);
    #2;
    rst_n = 1;
    mon_en = 1;

    // pass-through
    alu_op(64'h10001, 5, 1);
    idle(1);
    idle(1);
    // backpressure then drain in order
    alu_op(64'h11, 1, 0);
    alu_op(64'h22, 2, 0);
    idle(0);
    idle(0);
    repeat (4) idle(1);
    // BEQ taken, BNE not taken
    issue(1, 0, 1, 0, 1, 1, 0, 0, 64'h400, 0, 0, 0, 0);
    idle(1);
    issue(1, 0, 1, 1, 1, 1, 0, 0, 64'h800, 0, 0, 0, 0);
    idle(1);
    idle(1);
    // flush, then a write to x0
    issue(1, 1, 0, 0, 0, 1, 64'h55, 0, 0, 3, 1, 0, 0);
    idle(1);
    alu_op(64'h66, 0, 0);
    idle(0);
    repeat (2) idle(1);
    // load does not forward, younger ALU op in skid does
    issue(1, 0, 0, 0, 0, 0, 64'h700, 0, 0, 7, 1, 1, 0);
    idle(0);
    alu_op(64'h800, 8, 0);
    idle(0);
    repeat (3) idle(1);

    repeat (600) rand_cycle();
    repeat (4) idle(1);

    // reset with buffered entry and redirect pending
    alu_op(64'hA, 10, 0);
    alu_op(64'hB, 11, 0);
    issue(1, 0, 1, 0, 1, 1, 0, 0, 64'h900, 0, 0, 0, 0);
    issue(1, 0, 1, 0, 1, 0, 0, 0, 64'h940, 0, 0, 0, 0);
    idle(0);
    @(negedge clk);
    #1;
    mon_en = 0;
    rst_n = 0;
    #1;
    chk("mid-rst out_valid", out_valid, 0);
    chk("mid-rst redirect", redirect, 0);
    chk("mid-rst in_ready", in_ready, 1);
    chk("mid-rst fwdValid", fwdValid, 0);
    model_clear();
    in_valid = 0;
    @(posedge clk);
    #2;
    rst_n = 1;
    mon_en = 1;
    repeat (150) rand_cycle();
    repeat (4) idle(1);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM boundary of the RISC-V pipeline; sits directly downstream of the 64-bit ALU.
- Captures the ALU result, zero flag and EX control bits, resolves BEQ/BNE and issues a one-cycle PC redirect.
- Buffers up to two instructions in a skid buffer so MEM backpressure never drops an in-flight result.
- Drives a forwarding tap back to EX.

Parameters:
DATA_W, 64, width of ALU result, store data and PC
REG_W, 5, register-index width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  EX presents an instruction
in_ready  output  1  stage can accept (registered)
flush  input  1  kill the instruction presented this cycle
aluResult  input  DATA_W  ALU result
zeroFlag  input  1  1 when ALU result == 0
storeData  input  DATA_W  rs2 value for stores
rdAddr  input  REG_W  destination register
regWrite  input  1  writeback enable
memRead  input  1  load
memWrite  input  1  store
branch  input  1  conditional branch (ALU did sub)
branchNe  input  1  1=BNE, 0=BEQ
branchTarget  input  DATA_W  taken-branch PC
out_valid  output  1  head entry valid to MEM
out_ready  input  1  MEM accepts head
out_aluResult  output  DATA_W  head result/address
out_storeData  output  DATA_W  head store data
out_rd  output  REG_W  head rd
out_regWrite  output  1  head regWrite
out_memRead  output  1  head memRead
out_memWrite  output  1  head memWrite
redirect  output  1  one-cycle taken-branch pulse
redirectPc  output  DATA_W  target PC, valid with redirect
fwdValid  output  1  forwarding data valid
fwdRd  output  REG_W  forwarding destination
fwdData  output  DATA_W  forwarding value

Behaviour:
- Accept = in_valid & in_ready & ~flush. flush only kills the presented instruction; buffered entries are older and are kept.
- Storage: two entries, head (H) and skid (S), plus a 0..2 count. in_ready = (count != 2), registered from the next-state count.
- Dequeue = out_valid & out_ready. out_* come directly from H registers; out_valid = (count != 0).
- Simultaneous accept and dequeue:
  - count=1: the new entry becomes H; count stays 1.
  - count=2: S moves to H and the new entry goes to S; count stays 2 (unreachable with a registered in_ready, but must be handled).
- Accept only, count=0 → H. Accept only, count=1 → S. Dequeue only, count=2 → S shifts to H.
- Branch entry (branch=1) on accept:
  - taken = zeroFlag ^ branchNe.
  - Next cycle: redirect=1 for exactly one cycle if taken, and redirectPc = branchTarget. Redirect is independent of out_ready.
  - Branch entries are not enqueued; count is unchanged.
- Accepted entry with rdAddr == 0 has its stored regWrite forced to 0.
- Forwarding tap:
  - Source is the youngest valid entry (S if count=2, else H) with regWrite=1 and memRead=0.
  - That source drives fwdValid=1, fwdRd and fwdData=aluResult.
  - If the youngest entry does not qualify, fwdValid=0. Loads never forward.
- Ordering: out_* order equals accept order. No entry is lost or duplicated under any out_ready pattern.
- Reset (async assert, sync deassert is external):
  - count=0, out_valid=0, all out_* data/control = 0.
  - redirect=0, redirectPc=0, fwdValid=0, fwdRd=0, fwdData=0.
  - in_ready=1.
- Reset mid-operation discards all buffered entries and any pending redirect.
- Latency: 1 cycle from accept to out_valid when the stage is empty; 1 cycle from branch accept to redirect.

Test Plan:
- Pass-through: out_ready=1; accept aluResult=0x10001, rd=5, regWrite=1 → next cycle out_valid=1, out_aluResult=0x10001, out_rd=5, fwdValid=1, fwdRd=5.
- Backpressure: out_ready=0; accept A=0x11 then B=0x22 → in_ready=0 after the second accept. Raise out_ready → 0x11 then 0x22 are delivered, then in_ready returns to 1.
- Branch:
  - BEQ with zeroFlag=1, branchTarget=0x400 → redirect=1 for 1 cycle with redirectPc=0x400, out_valid unchanged.
  - BNE with zeroFlag=1 → no redirect.
- Flush/rd0: flush=1 with in_valid=1 → nothing enqueued. Accept rd=0, regWrite=1 → out_regWrite=0, fwdValid=0.
- Load forwarding: accept memRead=1, rd=7 → fwdValid=0. Then accept an ALU op rd=8 with out_ready=0 → fwdRd=8 (from S).
- Reset: two entries buffered and a redirect pending; pulse rst_n low → out_valid=0, redirect=0, in_ready=1 immediately.
